// File: rtl/am29811_next_addr_ctrl_pkg.sv
// Shared definitions for the Am29811-style next-address control slice.
//   - Opcode constants JZ..TWB (4'h0..4'hF), as seen in the microword MI field.
//   - Am2909 source-select encodings for the S output.
//   - D-source selector enum used between the decoder and the top-level D mux.
package am29811_next_addr_ctrl_pkg;

    // Opcode set
    localparam logic [3:0] JZ   = 4'h0;
    localparam logic [3:0] CJS  = 4'h1;
    localparam logic [3:0] JMAP = 4'h2;
    localparam logic [3:0] CJP  = 4'h3;
    localparam logic [3:0] PUSH = 4'h4;
    localparam logic [3:0] JSRP = 4'h5;
    localparam logic [3:0] CJV  = 4'h6;
    localparam logic [3:0] JRP  = 4'h7;
    localparam logic [3:0] RFCT = 4'h8;
    localparam logic [3:0] RPCT = 4'h9;
    localparam logic [3:0] CRTN = 4'hA;
    localparam logic [3:0] CJPP = 4'hB;
    localparam logic [3:0] LDCT = 4'hC;
    localparam logic [3:0] LOOP = 4'hD;
    localparam logic [3:0] CONT = 4'hE;
    localparam logic [3:0] TWB  = 4'hF;

    // Am2909 S encodings: microPC, address register, stack top, direct input
    localparam logic [1:0] SRC_UPC = 2'b00;
    localparam logic [1:0] SRC_AR  = 2'b01;
    localparam logic [1:0] SRC_STK = 2'b10;
    localparam logic [1:0] SRC_D   = 2'b11;

    // Which field drives the sequencer D input
    typedef enum logic [1:0] {
        DSRC_PL   = 2'd0,
        DSRC_MAP  = 2'd1,
        DSRC_VECT = 2'd2
    } dsrc_e;

endpackage

// File: rtl/am29811_decode.sv
// Combinational opcode decoder.
// Inputs : mi (pipelined opcode), pass (TEST xor POL), cnt_z (loop counter is zero).
// Outputs: s (Am2909 source select), fe (file enable, active-low),
//          pup (push=1/pop=0), zero (force Y=0, active-low),
//          dsel (D-source select), cnt_ld (load counter from PL),
//          cnt_dec (decrement counter).
// Defaults are "continue": S=uPC, no stack op, D from PL, counter held.
module am29811_decode
    import am29811_next_addr_ctrl_pkg::*;
(
    input  logic [3:0] mi,
    input  logic       pass,
    input  logic       cnt_z,
    output logic [1:0] s,
    output logic       fe,
    output logic       pup,
    output logic       zero,
    output dsrc_e      dsel,
    output logic       cnt_ld,
    output logic       cnt_dec
);

    always_comb begin
        s       = SRC_UPC;
        fe      = 1'b1;
        pup     = 1'b0;
        zero    = 1'b1;
        dsel    = DSRC_PL;
        cnt_ld  = 1'b0;
        cnt_dec = 1'b0;

        case (mi)
            JZ: zero = 1'b0;
            CJS: if (pass) begin
                s   = SRC_D;
                fe  = 1'b0;
                pup = 1'b1;
            end
            JMAP: begin
                s    = SRC_D;
                dsel = DSRC_MAP;
            end
            CJP: if (pass) s = SRC_D;
            PUSH: begin
                fe     = 1'b0;
                pup    = 1'b1;
                cnt_ld = pass;
            end
            JSRP: begin
                fe  = 1'b0;
                pup = 1'b1;
                s   = pass ? SRC_D : SRC_AR;
            end
            CJV: if (pass) begin
                s    = SRC_D;
                dsel = DSRC_VECT;
            end
            JRP: s = pass ? SRC_D : SRC_AR;
            RFCT: begin
                // Loop back to the stacked address until the count runs out,
                // then drop the loop address off the stack.
                if (!cnt_z) begin
                    s       = SRC_STK;
                    cnt_dec = 1'b1;
                end else begin
                    fe = 1'b0;
                end
            end
            RPCT: if (!cnt_z) begin
                s       = SRC_D;
                cnt_dec = 1'b1;
            end
            CRTN: if (pass) begin
                s  = SRC_STK;
                fe = 1'b0;
            end
            CJPP: if (pass) begin
                s  = SRC_D;
                fe = 1'b0;
            end
            LDCT: cnt_ld = 1'b1;
            LOOP: begin
                if (pass) fe = 1'b0;
                else      s  = SRC_STK;
            end
            CONT: ;
            TWB: begin
                // Three-way branch: keep looping on the stack while counting,
                // exit on PASS, or fall out to PL when the count expires.
                cnt_dec = !cnt_z;
                if (!cnt_z && !pass) begin
                    s = SRC_STK;
                end else if (cnt_z && !pass) begin
                    s  = SRC_D;
                    fe = 1'b0;
                end else begin
                    fe = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/am29811_next_addr_ctrl.sv
// Next-address control unit for an Am2909 sequencer.
// Captures the microword fields {MI,POL,RLD,PL} in a pipeline register each
// clock, keeps a loop counter, and combinationally produces the sequencer
// controls from the pipeline register, the counter and the live TEST input.
// Ports:
//   CP, RST            clock (posedge) and asynchronous active-high reset
//   UW_MI/POL/RLD/PL   microword fields from the control-store ROM
//   TEST               condition input, used in the same cycle
//   MAP, VECT          alternative D sources (mapping PROM, interrupt vector)
//   S, FE, PUP, RE,
//   ZERO, D            Am2909 control inputs
//   CNT, CNT_Z         loop counter and its zero flag
//   MI                 pipelined opcode, exposed for debug
module am29811_next_addr_ctrl
    import am29811_next_addr_ctrl_pkg::*;
#(
    parameter int AW = 4,
    parameter int CW = 4
) (
    input  logic          CP,
    input  logic          RST,
    input  logic [3:0]    UW_MI,
    input  logic          UW_POL,
    input  logic          UW_RLD,
    input  logic [AW-1:0] UW_PL,
    input  logic          TEST,
    input  logic [AW-1:0] MAP,
    input  logic [AW-1:0] VECT,
    output logic [1:0]    S,
    output logic          FE,
    output logic          PUP,
    output logic          RE,
    output logic          ZERO,
    output logic [AW-1:0] D,
    output logic [CW-1:0] CNT,
    output logic          CNT_Z,
    output logic [3:0]    MI
);

    // Wide enough for both PL and CNT so the load value can be truncated or
    // zero-extended with a single slice.
    localparam int XW = (AW > CW) ? AW : CW;

    logic [3:0]    mi_q;
    logic          pol_q;
    logic          rld_q;
    logic [AW-1:0] pl_q;
    logic [CW-1:0] cnt_q;

    logic          pass;
    logic          cnt_z;
    dsrc_e         dsel;
    logic          cnt_ld;
    logic          cnt_dec;
    logic [XW-1:0] pl_ext;
    logic [CW-1:0] pl_cnt;

    // Reset leaves JZ in the pipeline so the sequencer is held at address 0.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            mi_q  <= JZ;
            pol_q <= 1'b0;
            rld_q <= 1'b0;
            pl_q  <= '0;
        end else begin
            mi_q  <= UW_MI;
            pol_q <= UW_POL;
            rld_q <= UW_RLD;
            pl_q  <= UW_PL;
        end
    end

    assign pass   = TEST ^ pol_q;
    assign cnt_z  = (cnt_q == '0);
    assign pl_ext = XW'(pl_q);
    assign pl_cnt = pl_ext[CW-1:0];

    am29811_decode u_decode (
        .mi      (mi_q),
        .pass    (pass),
        .cnt_z   (cnt_z),
        .s       (S),
        .fe      (FE),
        .pup     (PUP),
        .zero    (ZERO),
        .dsel    (dsel),
        .cnt_ld  (cnt_ld),
        .cnt_dec (cnt_dec)
    );

    // The decoder never asserts load and decrement together; the zero guard
    // on decrement keeps the counter from wrapping.
    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (cnt_ld) begin
            cnt_q <= pl_cnt;
        end else if (cnt_dec && !cnt_z) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_comb begin
        case (dsel)
            DSRC_MAP:  D = MAP;
            DSRC_VECT: D = VECT;
            default:   D = pl_q;
        endcase
    end

    assign RE    = ~rld_q;
    assign CNT   = cnt_q;
    assign CNT_Z = cnt_z;
    assign MI    = mi_q;

endmodule

// File: tb/tb_am29811_next_addr_ctrl.sv
// Directed bench for am29811_next_addr_ctrl: reset sequence, a table of
// per-cycle vectors with hand-computed outputs, and an async-reset sequence.
module tb_am29811_next_addr_ctrl;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          CP;
    logic          RST;
    logic [3:0]    UW_MI;
    logic          UW_POL;
    logic          UW_RLD;
    logic [AW-1:0] UW_PL;
    logic          TEST;
    logic [AW-1:0] MAP;
    logic [AW-1:0] VECT;
    logic [1:0]    S;
    logic          FE;
    logic          PUP;
    logic          RE;
    logic          ZERO;
    logic [AW-1:0] D;
    logic [CW-1:0] CNT;
    logic          CNT_Z;
    logic [3:0]    MI;

    int checks   = 0;
    int failures = 0;

    am29811_next_addr_ctrl #(.AW(AW), .CW(CW)) dut (
        .CP     (CP),
        .RST    (RST),
        .UW_MI  (UW_MI),
        .UW_POL (UW_POL),
        .UW_RLD (UW_RLD),
        .UW_PL  (UW_PL),
        .TEST   (TEST),
        .MAP    (MAP),
        .VECT   (VECT),
        .S      (S),
        .FE     (FE),
        .PUP    (PUP),
        .RE     (RE),
        .ZERO   (ZERO),
        .D      (D),
        .CNT    (CNT),
        .CNT_Z  (CNT_Z),
        .MI     (MI)
    );

    // Clock / reset
    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Vector record: microword + TEST, then outputs expected while that
    // microword sits in the pipeline register (CNT is the value during it).
    typedef struct {
        logic [3:0] mi;
        logic       pol;
        logic       rld;
        logic [3:0] pl;
        logic       test;
        logic [1:0] e_s;
        logic       e_fe;
        logic       e_pup;
        logic       e_re;
        logic       e_zero;
        logic [3:0] e_d;
        logic [3:0] e_cnt;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs[NV];

    logic [18:0] exp_q[$];

    function automatic vec_t mk(logic [3:0] mi, logic pol, logic rld, logic [3:0] pl,
                                logic test, logic [1:0] s, logic fe, logic pup,
                                logic re, logic zero, logic [3:0] d, logic [3:0] cnt);
        vec_t v;
        v.mi = mi; v.pol = pol; v.rld = rld; v.pl = pl; v.test = test;
        v.e_s = s; v.e_fe = fe; v.e_pup = pup; v.e_re = re; v.e_zero = zero;
        v.e_d = d; v.e_cnt = cnt;
        return v;
    endfunction

    function automatic logic [18:0] pack(logic [1:0] s, logic fe, logic pup, logic re,
                                         logic zero, logic [3:0] d, logic [3:0] cnt,
                                         logic cz, logic [3:0] mi);
        return {s, fe, pup, re, zero, d, cnt, cz, mi};
    endfunction

    function automatic logic [18:0] act_word();
        return pack(S, FE, PUP, RE, ZERO, D, CNT, CNT_Z, MI);
    endfunction

    // Scoreboard compare: pops the oldest expectation
    task automatic check_word(input string name);
        logic [18:0] exp_w;
        logic [18:0] act_w;
        exp_w = exp_q.pop_front();
        act_w = act_word();
        checks++;
        if (act_w !== exp_w) begin
            failures++;
            $display("FAIL %s: actual {S,FE,PUP,RE,ZERO,D,CNT,CNT_Z,MI}=%05h required=%05h",
                     name, act_w, exp_w);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
        end
    endtask

    // Drivers
    task automatic drive_uw(input logic [3:0] mi, input logic pol, input logic rld,
                            input logic [3:0] pl);
        UW_MI  = mi;
        UW_POL = pol;
        UW_RLD = rld;
        UW_PL  = pl;
    endtask

    task automatic apply_vec(input vec_t v);
        drive_uw(v.mi, v.pol, v.rld, v.pl);
        @(posedge CP);
        #1;
        TEST = v.test;
        #1;
    endtask

    initial begin
        //            mi    pol  rld  pl    test  S      FE   PUP  RE   ZERO D     CNT
        vecs[0]  = mk(4'hC, 1'b0,1'b0,4'h3, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h3, 4'h0);
        vecs[1]  = mk(4'h9, 1'b0,1'b0,4'hA, 1'b0, 2'b11, 1'b1,1'b0,1'b1,1'b1,4'hA, 4'h3);
        vecs[2]  = mk(4'h9, 1'b0,1'b0,4'hA, 1'b0, 2'b11, 1'b1,1'b0,1'b1,1'b1,4'hA, 4'h2);
        vecs[3]  = mk(4'h9, 1'b0,1'b0,4'hA, 1'b0, 2'b11, 1'b1,1'b0,1'b1,1'b1,4'hA, 4'h1);
        vecs[4]  = mk(4'h9, 1'b0,1'b0,4'hA, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'hA, 4'h0);
        vecs[5]  = mk(4'h1, 1'b0,1'b0,4'h7, 1'b1, 2'b11, 1'b0,1'b1,1'b1,1'b1,4'h7, 4'h0);
        vecs[6]  = mk(4'h1, 1'b0,1'b0,4'h7, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h7, 4'h0);
        vecs[7]  = mk(4'h1, 1'b1,1'b0,4'h7, 1'b0, 2'b11, 1'b0,1'b1,1'b1,1'b1,4'h7, 4'h0);
        vecs[8]  = mk(4'hA, 1'b0,1'b0,4'h0, 1'b1, 2'b10, 1'b0,1'b0,1'b1,1'b1,4'h0, 4'h0);
        vecs[9]  = mk(4'hA, 1'b0,1'b0,4'h0, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h0, 4'h0);
        vecs[10] = mk(4'hC, 1'b0,1'b0,4'h2, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h2, 4'h0);
        vecs[11] = mk(4'hF, 1'b0,1'b0,4'hC, 1'b0, 2'b10, 1'b1,1'b0,1'b1,1'b1,4'hC, 4'h2);
        vecs[12] = mk(4'hF, 1'b0,1'b0,4'hC, 1'b0, 2'b10, 1'b1,1'b0,1'b1,1'b1,4'hC, 4'h1);
        vecs[13] = mk(4'hF, 1'b0,1'b0,4'hC, 1'b0, 2'b11, 1'b0,1'b0,1'b1,1'b1,4'hC, 4'h0);
        vecs[14] = mk(4'h2, 1'b0,1'b0,4'h1, 1'b0, 2'b11, 1'b1,1'b0,1'b1,1'b1,4'h9, 4'h0);
        vecs[15] = mk(4'h6, 1'b0,1'b0,4'h1, 1'b1, 2'b11, 1'b1,1'b0,1'b1,1'b1,4'h5, 4'h0);
        vecs[16] = mk(4'hE, 1'b0,1'b1,4'h4, 1'b0, 2'b00, 1'b1,1'b0,1'b0,1'b1,4'h4, 4'h0);
        vecs[17] = mk(4'hE, 1'b0,1'b0,4'h4, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h4, 4'h0);
        vecs[18] = mk(4'h4, 1'b0,1'b0,4'h6, 1'b1, 2'b00, 1'b0,1'b1,1'b1,1'b1,4'h6, 4'h0);
        vecs[19] = mk(4'h8, 1'b0,1'b0,4'h0, 1'b0, 2'b10, 1'b1,1'b0,1'b1,1'b1,4'h0, 4'h6);
        vecs[20] = mk(4'h5, 1'b0,1'b0,4'hB, 1'b0, 2'b01, 1'b0,1'b1,1'b1,1'b1,4'hB, 4'h5);
        vecs[21] = mk(4'h5, 1'b0,1'b0,4'hB, 1'b1, 2'b11, 1'b0,1'b1,1'b1,1'b1,4'hB, 4'h5);
        vecs[22] = mk(4'h7, 1'b0,1'b0,4'h3, 1'b0, 2'b01, 1'b1,1'b0,1'b1,1'b1,4'h3, 4'h5);
        vecs[23] = mk(4'hD, 1'b0,1'b0,4'h0, 1'b0, 2'b10, 1'b1,1'b0,1'b1,1'b1,4'h0, 4'h5);
        vecs[24] = mk(4'hD, 1'b0,1'b0,4'h0, 1'b1, 2'b00, 1'b0,1'b0,1'b1,1'b1,4'h0, 4'h5);
        vecs[25] = mk(4'hB, 1'b0,1'b0,4'h8, 1'b1, 2'b11, 1'b0,1'b0,1'b1,1'b1,4'h8, 4'h5);
        vecs[26] = mk(4'h3, 1'b1,1'b0,4'h8, 1'b0, 2'b11, 1'b1,1'b0,1'b1,1'b1,4'h8, 4'h5);
        vecs[27] = mk(4'h4, 1'b0,1'b0,4'h9, 1'b0, 2'b00, 1'b0,1'b1,1'b1,1'b1,4'h9, 4'h5);
        vecs[28] = mk(4'h0, 1'b0,1'b0,4'h0, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b0,4'h0, 4'h5);
        vecs[29] = mk(4'hF, 1'b0,1'b0,4'h2, 1'b1, 2'b00, 1'b0,1'b0,1'b1,1'b1,4'h2, 4'h5);
        vecs[30] = mk(4'hE, 1'b0,1'b0,4'h0, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h0, 4'h4);
        vecs[31] = mk(4'hC, 1'b0,1'b0,4'h0, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h0, 4'h4);
        vecs[32] = mk(4'h8, 1'b0,1'b0,4'h0, 1'b0, 2'b00, 1'b0,1'b0,1'b1,1'b1,4'h0, 4'h0);
        vecs[33] = mk(4'hF, 1'b0,1'b0,4'h0, 1'b1, 2'b00, 1'b0,1'b0,1'b1,1'b1,4'h0, 4'h0);
        vecs[34] = mk(4'hE, 1'b0,1'b0,4'h0, 1'b0, 2'b00, 1'b1,1'b0,1'b1,1'b1,4'h0, 4'h0);

        // Reset: JZ held in the pipeline
        RST  = 1'b1;
        TEST = 1'b0;
        MAP  = 4'h9;
        VECT = 4'h5;
        drive_uw(4'hE, 1'b0, 1'b0, 4'h0);
        #20;
        RST = 1'b0;
        #2;
        exp_q.push_back(pack(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0));
        check_word("reset_state");

        // First edge brings in CONT
        @(posedge CP);
        #2;
        exp_q.push_back(pack(2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 4'hE));
        check_word("first_cont");

        // Vector table
        for (int i = 0; i < NV; i++) begin
            apply_vec(vecs[i]);
            exp_q.push_back(pack(vecs[i].e_s, vecs[i].e_fe, vecs[i].e_pup, vecs[i].e_re,
                                 vecs[i].e_zero, vecs[i].e_d, vecs[i].e_cnt,
                                 (vecs[i].e_cnt == 4'h0), vecs[i].mi));
            check_word($sformatf("vec%0d", i));
        end

        // TEST is combinational: flip it mid-cycle with CJP in the pipeline
        drive_uw(4'h3, 1'b0, 1'b0, 4'h6);
        @(posedge CP);
        #1;
        TEST = 1'b0;
        #1;
        check_bit("cjp_test0_s1", S[1], 1'b0);
        TEST = 1'b1;
        #1;
        check_bit("cjp_test1_s1", S[1], 1'b1);

        // Asynchronous reset between edges clears counter and pipeline
        drive_uw(4'hC, 1'b0, 1'b0, 4'h7);
        @(posedge CP);
        #1;
        drive_uw(4'hE, 1'b0, 1'b1, 4'h3);
        @(posedge CP);
        #1;
        check_bit("pre_rst_cnt7", (CNT == 4'h7), 1'b1);
        #1;
        RST = 1'b1;
        #1;
        exp_q.push_back(pack(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0));
        check_word("async_reset");
        #1;
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/am29811_next_addr_ctrl.md
Name: am29811_next_addr_ctrl

Overview:
- Next-address control unit that drives an Am2909 sequencer's S, FE, PUP, RE, ZERO and D inputs.
- It sits at the other end of the sequencer interface: the microcode ROM output at address Y is captured in a microinstruction pipeline register.
- A 16-instruction Am29811-style opcode set is decoded against TEST, together with an internal loop counter.
- The resulting next-address controls close the fetch loop.

Parameters:
- AW, 4, address width (matches the Am2909 D/R/Y width).
- CW, 4, loop counter width.

Ports:
- CP  in  1  clock; all registers update on posedge.
- RST  in  1  asynchronous reset, active-high.
- UW_MI  in  4  opcode field from microcode ROM.
- UW_POL  in  1  test polarity; 1 inverts TEST.
- UW_RLD  in  1  load the sequencer address register this cycle.
- UW_PL  in  AW  branch/count literal field.
- TEST  in  1  condition input; combinational, sampled in the current cycle.
- MAP  in  AW  mapping-PROM address.
- VECT  in  AW  interrupt vector address.
- S  out  2  sequencer source select.
- FE  out  1  file enable, active-low.
- PUP  out  1  push(1)/pop(0).
- RE  out  1  address register enable, active-low.
- ZERO  out  1  force Y=0, active-low.
- D  out  AW  sequencer direct input.
- CNT  out  CW  loop counter value.
- CNT_Z  out  1  CNT==0.
- MI  out  4  pipelined opcode (debug).

Behaviour:
- Pipeline register {MI,POL,RLD,PL} loads from UW_* every posedge.
- RST forces MI=JZ(0), POL=0, RLD=0, PL=0 and CNT=0, so after reset the outputs are ZERO=0, S=00, FE=1, RE=1 and Y=0.
- Outputs are combinational from the pipeline register, CNT and TEST. There is no clock latency between TEST and outputs.
- PASS = TEST XOR POL. RE = ~RLD. ZERO = 0 only for JZ.
- Default outputs: S=00, FE=1, PUP=0, D=PL, CNT held.
- Opcodes (a 'jump' sets S=11; 'push' sets FE=0, PUP=1; 'pop' sets FE=0, PUP=0):
  - 0 JZ: ZERO=0, S=00.
  - 1 CJS: if PASS, jump to PL and push; else continue.
  - 2 JMAP: jump with D=MAP.
  - 3 CJP: if PASS, jump to PL.
  - 4 PUSH: push, continue; if PASS, CNT<=PL[CW-1:0].
  - 5 JSRP: push always; if PASS, jump to PL, else S=01 (R).
  - 6 CJV: if PASS, jump with D=VECT.
  - 7 JRP: if PASS, jump to PL, else S=01.
  - 8 RFCT: if CNT!=0, S=10 and CNT--; else pop, continue.
  - 9 RPCT: if CNT!=0, jump to PL and CNT--; else continue.
  - A CRTN: if PASS, S=10 and pop.
  - B CJPP: if PASS, jump to PL and pop.
  - C LDCT: CNT<=PL, continue.
  - D LOOP: if PASS, pop and continue; else S=10.
  - E CONT: continue.
  - F TWB:
    - CNT!=0 and !PASS: S=10, CNT--.
    - CNT!=0 and PASS: pop, continue, CNT--.
    - CNT==0 and !PASS: jump to PL, pop.
    - CNT==0 and PASS: pop, continue.
- Counter rules:
  - Decrement only when CNT!=0, so no wrap below zero.
  - The load uses PL truncated or zero-extended to CW.
  - Load and decrement never occur in the same instruction.
- RST asserted mid-instruction clears the pipeline register and CNT immediately and asynchronously. Stack state in the sequencer is not this block's concern.
- All outputs are fully defined (no X) for every opcode/TEST/CNT combination.

Decomposition:
- Shared package holds:
  - opcode constants JZ..TWB (4'h0..4'hF);
  - S encodings SRC_UPC=00, SRC_AR=01, SRC_STK=10, SRC_D=11;
  - D-source enum DSRC_PL/DSRC_MAP/DSRC_VECT.
- One sub-module, am29811_decode: purely combinational {MI,PASS,CNT_Z} -> {S,FE,PUP,ZERO,dsel,cnt_ld,cnt_dec}.
- The top level holds the pipeline register, counter and D mux.

Test Plan:
- RST=1 for 20ns, then release with UW=CONT -> before first edge: ZERO=0, S=00, FE=1, RE=1, CNT=0. After one posedge: ZERO=1, S=00.
- UW_MI=LDCT, UW_PL=4'h3, then RPCT with PL=4'hA for 4 cycles -> CNT 3,2,1,0. S=11, D=4'hA on the first three RPCT cycles, S=00 on the fourth.
- CJS, PL=4'h7:
  - TEST=1, POL=0 -> S=11, D=4'h7, FE=0, PUP=1.
  - TEST=0 -> S=00, FE=1.
  - POL=1, TEST=0 -> jump taken.
- CRTN with PASS=1 -> S=10, FE=0, PUP=0. With PASS=0 -> S=00, FE=1.
- TWB with CNT=2 (loaded via LDCT), TEST=0 -> S=10, CNT becomes 1. Then with CNT=0, TEST=0, PL=4'hC -> S=11, D=4'hC, FE=0, PUP=0.
- JMAP with MAP=4'h9 -> S=11, D=4'h9. CJV with VECT=4'h5, TEST=1 -> D=4'h5. UW_RLD=1 -> RE=0 on that cycle only.
